beep_sequencer: RTL and testbench
=================================

# beep_sequencer

Note sequencer for the south-bridge beeper controller. It accepts queued (tone, duration) commands from the CPU-side register interface and buffers them in a small FIFO. It plays each command by driving the beeper's 8-bit control byte for an exact number of prescaled ticks, with an optional silent gap between notes. It also raises a pulse when the queue drains, so software can stream melodies without cycle-accurate polling.

## Interface
Parameters:
- FIFO_DEPTH, 8: note queue entries; power of two, ≥2.
- TICK_DIV, 1000: CLK cycles per duration tick; ≥1, 16-bit.
- GAP_TICKS, 1: silent ticks inserted after every note; 0 disables the gap.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous, active-low reset.
- WR_EN  in  1  queue write strobe, one entry per cycle.
- WR_DATA  in  16  [15:8] DUR (ticks, 0 means 256), [7:0] TONE (beeper control byte).
- WR_FULL  out  1  queue full; a write is dropped while this is high.
- ABORT  in  1  flush the queue and silence the output.
- CTL  out  8  control byte to the beeper controller; 8'h00 is silence.
- BUSY  out  1  high in PLAY or GAP.
- LEVEL  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.
- DONE  out  1  one-cycle pulse when playback ends with the queue empty.

## Operation
- The FSM has three states: IDLE, PLAY, GAP.
- **Reset (async):** state=IDLE, CTL=8'h00, BUSY=0, DONE=0, LEVEL=0, WR_FULL=0. The queue is emptied and the prescaler and tick counter are cleared.
- **IDLE:** CTL=8'h00.
  - If the queue is non-empty: pop the head, load CTL←TONE, load tick counter←DUR (0→256), load prescaler←TICK_DIV-1, and go to PLAY.
- **PLAY:**
  - The prescaler decrements every cycle.
  - When the prescaler reaches 0, it reloads and the tick counter decrements.
  - The note ends in the cycle where the prescaler is 0 and the tick counter is 1. Then:
    - If GAP_TICKS>0: CTL←8'h00, load tick counter←GAP_TICKS, go to GAP.
    - Else if the queue is non-empty: pop and reload as in IDLE, and stay in PLAY. Notes play back-to-back with no idle cycle.
    - Else: CTL←8'h00, pulse DONE, go to IDLE.
- **GAP:** CTL=8'h00. The counting rules match PLAY. At the end of the gap:
  - If the queue is non-empty: pop and go to PLAY.
  - Else: pulse DONE and go to IDLE.
- **Queue write:**
  - An accepted write (WR_EN & !WR_FULL) is visible to the FSM in the next cycle.
  - A write and a pop in the same cycle are both honoured; LEVEL stays unchanged.
  - A write when full is dropped, even if a pop occurs in that cycle.
- **ABORT (synchronous):** has priority over all other activity. On the next edge:
  - The queue is empty, state=IDLE, CTL=8'h00.
  - A concurrent write is discarded.
  - DONE is not pulsed.
- Width rules:
  - The tick counter is 9 bits, so DUR=0 plays 256 ticks.
  - The prescaler is 16 bits.
  - LEVEL never wraps.

## Timing
- Start-up latency: a write accepted in cycle N makes the queue non-empty in cycle N+1. The IDLE pop occurs in N+1, and CTL=TONE is valid from cycle N+2.
- Each note holds CTL=TONE for exactly DUR·TICK_DIV cycles.
- Each gap holds CTL=8'h00 for exactly GAP_TICKS·TICK_DIV cycles.
- DONE is asserted in the first cycle of IDLE.
- WR_FULL and LEVEL are registered and reflect the state after the previous edge.
- Reset asserted mid-note forces CTL=8'h00 immediately. No note resumes after reset.

## Structure
- Package beep_pkg contains:
  - the state enum (IDLE/PLAY/GAP);
  - the packed entry type {dur[7:0], tone[7:0]};
  - the silence constant 8'h00;
  - the DUR_W=8 and TICK_W=9 width constants.
- Sub-module beep_fifo: a synchronous FIFO with async active-low reset. It has push/pop, full/empty and level outputs, and a flush input driven by ABORT.
- The FSM, prescaler and tick counter live in beep_sequencer.

## Test plan
- **Single note.** Set TICK_DIV=4, GAP_TICKS=0, and write {DUR=3,TONE=8'h40} in cycle 0. Required: CTL=8'h40 for cycles 2–13, 8'h00 from cycle 14, and DONE high in cycle 14 only.
- **Back-to-back with gap.** Set TICK_DIV=2, GAP_TICKS=1, and queue notes {2,8'h10} and {1,8'h20}. Required: 4 cycles of 10, then 2 cycles of 00, then 2 cycles of 20, then 2 cycles of 00, then DONE.
- **Full queue.** Set FIFO_DEPTH=4 and make 5 writes while a long note plays. Required: WR_FULL=1 after the 4th write, the 5th write is dropped, and LEVEL=4.
- **Simultaneous write and pop at full.** Required: the write is dropped, and LEVEL drops to 3.
- **DUR=0.** Set TICK_DIV=1 and write {0,8'h7F}. Required: CTL=8'h7F for exactly 256 cycles.
- **Abort and reset mid-note.**
  - ABORT during the second of three queued notes: CTL=8'h00 the next cycle, LEVEL=0, and no DONE.
  - nRST low mid-note: CTL=8'h00 asynchronously.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared types and constants for the beeper note sequencer.
package beep_pkg;

  localparam int DUR_W  = 8;
  localparam int TICK_W = 9;

  localparam logic [7:0] SILENCE = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  typedef struct packed {
    logic [DUR_W-1:0] dur;
    logic [7:0]       tone;
  } entry_t;

  // A duration of zero encodes the longest note, 256 ticks.
  function automatic logic [TICK_W-1:0] dur_ticks(input logic [DUR_W-1:0] d);
    return (d == '0) ? {1'b1, 8'h00} : {1'b0, d};
  endfunction

endpackage

// File: rtl/beep_fifo.sv
// Note queue: synchronous FIFO with registered occupancy and a flush input.
module beep_fifo
  import beep_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  entry_t                   i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output entry_t                   o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  // A full queue drops the write even when a pop frees a slot this cycle.
  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/beep_sequencer.sv
// Plays queued (tone, duration) notes on the beeper control byte, with an
// optional silent gap after each note and a DONE pulse when the queue drains.
module beep_sequencer
  import beep_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TICK_DIV   = 1000,
  parameter int GAP_TICKS  = 1
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          WR_EN,
  input  logic [15:0]                   WR_DATA,
  output logic                          WR_FULL,
  input  logic                          ABORT,
  output logic [7:0]                    CTL,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          DONE
);

  localparam logic [15:0]       PRESC_LOAD = 16'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] GAP_LOAD   = TICK_W'(GAP_TICKS);

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_ctl, w_ctl_nxt;
  logic [15:0]         r_presc, w_presc_nxt;
  logic [TICK_W-1:0]   r_tick, w_tick_nxt;
  logic                r_done, w_done_nxt;
  logic                w_pop;
  logic                w_empty;
  entry_t              w_head;

  beep_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_push  (WR_EN),
    .i_data  (entry_t'(WR_DATA)),
    .i_pop   (w_pop),
    .i_flush (ABORT),
    .o_head  (w_head),
    .o_full  (WR_FULL),
    .o_empty (w_empty),
    .o_level (LEVEL)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_ctl   <= SILENCE;
      r_presc <= '0;
      r_tick  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ctl   <= w_ctl_nxt;
      r_presc <= w_presc_nxt;
      r_tick  <= w_tick_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ctl_nxt   = r_ctl;
    w_presc_nxt = r_presc;
    w_tick_nxt  = r_tick;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;
    if (ABORT) begin
      w_state_nxt = IDLE;
      w_ctl_nxt   = SILENCE;
      w_presc_nxt = '0;
      w_tick_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_ctl_nxt = SILENCE;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_ctl_nxt   = w_head.tone;
            w_tick_nxt  = dur_ticks(w_head.dur);
            w_presc_nxt = PRESC_LOAD;
            w_state_nxt = PLAY;
          end
        end
        PLAY, GAP: begin
          if (r_presc != '0) begin
            w_presc_nxt = r_presc - 1'b1;
          end else if (r_tick != TICK_W'(1)) begin
            w_presc_nxt = PRESC_LOAD;
            w_tick_nxt  = r_tick - 1'b1;
          end else if (r_state == PLAY && GAP_TICKS > 0) begin
            w_ctl_nxt   = SILENCE;
            w_presc_nxt = PRESC_LOAD;
            w_tick_nxt  = GAP_LOAD;
            w_state_nxt = GAP;
          end else if (!w_empty) begin
            // Chain straight into the next note with no idle cycle.
            w_pop       = 1'b1;
            w_ctl_nxt   = w_head.tone;
            w_tick_nxt  = dur_ticks(w_head.dur);
            w_presc_nxt = PRESC_LOAD;
            w_state_nxt = PLAY;
          end else begin
            w_ctl_nxt   = SILENCE;
            w_presc_nxt = '0;
            w_tick_nxt  = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_ctl_nxt   = SILENCE;
        end
      endcase
    end
  end

  assign CTL  = r_ctl;
  assign BUSY = (r_state != IDLE);
  assign DONE = r_done;

endmodule

// File: tb/tb_beep_sequencer.sv
// Scoreboard bench: three sequencer configurations share one clock; stimulus
// schedules per-cycle expectations, a negedge monitor compares them.
module tb_beep_sequencer;

  localparam int K_CTL  = 0;
  localparam int K_DONE = 1;
  localparam int K_LVL  = 2;
  localparam int K_FULL = 3;
  localparam int K_BUSY = 4;

  typedef struct {
    int cyc;
    int dut;
    int kind;
    int val;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nrst;
  logic        wr_en   [3];
  logic [15:0] wr_data [3];
  logic        abort   [3];
  logic        full    [3];
  logic        busy    [3];
  logic        done    [3];
  logic [7:0]  ctl     [3];
  logic [2:0]  lvl_a;
  logic [3:0]  lvl_b;
  logic [3:0]  lvl_c;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t m_e;
  int   m_act;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  beep_sequencer #(.FIFO_DEPTH(4), .TICK_DIV(4), .GAP_TICKS(0)) dut_a (
    .CLK(CLK), .nRST(nrst), .WR_EN(wr_en[0]), .WR_DATA(wr_data[0]),
    .WR_FULL(full[0]), .ABORT(abort[0]), .CTL(ctl[0]), .BUSY(busy[0]),
    .LEVEL(lvl_a), .DONE(done[0]));

  beep_sequencer #(.FIFO_DEPTH(8), .TICK_DIV(2), .GAP_TICKS(1)) dut_b (
    .CLK(CLK), .nRST(nrst), .WR_EN(wr_en[1]), .WR_DATA(wr_data[1]),
    .WR_FULL(full[1]), .ABORT(abort[1]), .CTL(ctl[1]), .BUSY(busy[1]),
    .LEVEL(lvl_b), .DONE(done[1]));

  beep_sequencer #(.FIFO_DEPTH(8), .TICK_DIV(1), .GAP_TICKS(0)) dut_c (
    .CLK(CLK), .nRST(nrst), .WR_EN(wr_en[2]), .WR_DATA(wr_data[2]),
    .WR_FULL(full[2]), .ABORT(abort[2]), .CTL(ctl[2]), .BUSY(busy[2]),
    .LEVEL(lvl_c), .DONE(done[2]));

  function automatic int sample(input int d, input int k);
    case (k)
      K_CTL:   return int'(ctl[d]);
      K_DONE:  return int'(done[d]);
      K_FULL:  return int'(full[d]);
      K_BUSY:  return int'(busy[d]);
      default: return (d == 0) ? int'(lvl_a) : (d == 1) ? int'(lvl_b) : int'(lvl_c);
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_CTL:   return "CTL";
      K_DONE:  return "DONE";
      K_FULL:  return "WR_FULL";
      K_BUSY:  return "BUSY";
      default: return "LEVEL";
    endcase
  endfunction

  task automatic expect_at(input int c, input int d, input int k, input int v);
    exp_t e;
    int   i;
    e = '{c, d, k, v};
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, e);
  endtask

  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e   = q.pop_front();
      m_act = sample(m_e.dut, m_e.kind);
      checks++;
      if (m_e.cyc != cyc || m_act != m_e.val) begin
        failures++;
        $display("FAIL %s dut%0d cycle=%0d (seen at %0d) got=%0h expected=%0h",
                 kname(m_e.kind), m_e.dut, m_e.cyc, cyc, m_act, m_e.val);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int d, input int dur, input int tone);
    wr_en[d]   = 1'b1;
    wr_data[d] = {8'(dur), 8'(tone)};
    tick();
    wr_en[d]   = 1'b0;
  endtask

  int c0;

  initial begin
    nrst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      wr_en[d] = 1'b0; wr_data[d] = '0; abort[d] = 1'b0;
    end
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      expect_at(cyc, d, K_CTL, 0);  expect_at(cyc, d, K_BUSY, 0);
      expect_at(cyc, d, K_DONE, 0); expect_at(cyc, d, K_LVL, 0);
      expect_at(cyc, d, K_FULL, 0);
    end
    tick();
    nrst = 1'b1;
    tick();

    // Single note {3,40}, TICK_DIV=4, no gap.
    c0 = cyc;
    for (int i = 1; i <= 15; i++) begin
      expect_at(c0 + i, 0, K_CTL, (i >= 2 && i <= 13) ? 'h40 : 0);
      expect_at(c0 + i, 0, K_DONE, (i == 14) ? 1 : 0);
    end
    expect_at(c0 + 1, 0, K_LVL, 1);  expect_at(c0 + 2, 0, K_LVL, 0);
    expect_at(c0 + 2, 0, K_BUSY, 1); expect_at(c0 + 14, 0, K_BUSY, 0);
    wr(0, 3, 'h40);
    repeat (16) tick();

    // Two notes with a one-tick gap, TICK_DIV=2.
    c0 = cyc;
    for (int i = 1; i <= 13; i++) begin
      expect_at(c0 + i, 1, K_CTL, (i >= 2 && i <= 5) ? 'h10 : (i >= 8 && i <= 9) ? 'h20 : 0);
      expect_at(c0 + i, 1, K_DONE, (i == 12) ? 1 : 0);
    end
    expect_at(c0 + 7, 1, K_BUSY, 1); expect_at(c0 + 12, 1, K_BUSY, 0);
    wr(1, 2, 'h10);
    wr(1, 1, 'h20);
    repeat (14) tick();

    // DUR=0 plays 256 ticks at TICK_DIV=1.
    c0 = cyc;
    for (int i = 1; i <= 259; i++)
      expect_at(c0 + i, 2, K_CTL, (i >= 2 && i <= 257) ? 'h7F : 0);
    expect_at(c0 + 257, 2, K_DONE, 0); expect_at(c0 + 258, 2, K_DONE, 1);
    wr(2, 0, 'h7F);
    repeat (260) tick();

    // Fill the 4-deep queue during a long note; then write on the pop cycle.
    c0 = cyc;
    expect_at(c0 + 7, 0, K_FULL, 0);   expect_at(c0 + 8, 0, K_FULL, 1);
    expect_at(c0 + 8, 0, K_LVL, 4);    expect_at(c0 + 9, 0, K_LVL, 4);
    expect_at(c0 + 9, 0, K_FULL, 1);   expect_at(c0 + 401, 0, K_CTL, 'h55);
    expect_at(c0 + 401, 0, K_LVL, 4);  expect_at(c0 + 401, 0, K_FULL, 1);
    expect_at(c0 + 402, 0, K_LVL, 3);  expect_at(c0 + 402, 0, K_FULL, 0);
    expect_at(c0 + 402, 0, K_CTL, 1);  expect_at(c0 + 405, 0, K_CTL, 1);
    expect_at(c0 + 406, 0, K_CTL, 2);  expect_at(c0 + 410, 0, K_CTL, 3);
    expect_at(c0 + 414, 0, K_CTL, 4);  expect_at(c0 + 417, 0, K_CTL, 4);
    expect_at(c0 + 418, 0, K_CTL, 0);  expect_at(c0 + 417, 0, K_DONE, 0);
    expect_at(c0 + 418, 0, K_DONE, 1); expect_at(c0 + 418, 0, K_LVL, 0);
    expect_at(c0 + 418, 0, K_BUSY, 0); expect_at(c0 + 419, 0, K_CTL, 0);
    wr(0, 100, 'h55);
    repeat (3) tick();
    for (int t = 1; t <= 5; t++) wr(0, 1, (t == 5) ? 'hEE : t);
    repeat (401 - 9) tick();
    wr(0, 1, 'hEE);
    repeat (20) tick();

    // Abort during the second of three notes, with a concurrent write.
    c0 = cyc;
    expect_at(c0 + 9, 0, K_CTL, 'hA1);  expect_at(c0 + 10, 0, K_CTL, 'hA2);
    expect_at(c0 + 12, 0, K_CTL, 'hA2); expect_at(c0 + 12, 0, K_LVL, 1);
    expect_at(c0 + 13, 0, K_LVL, 0);    expect_at(c0 + 13, 0, K_BUSY, 0);
    for (int i = 13; i <= 20; i++) begin
      expect_at(c0 + i, 0, K_CTL, 0);
      expect_at(c0 + i, 0, K_DONE, 0);
    end
    wr(0, 2, 'hA1);
    wr(0, 2, 'hA2);
    wr(0, 2, 'hA3);
    repeat (9) tick();
    abort[0] = 1'b1;
    wr(0, 1, 'hBB);
    abort[0] = 1'b0;
    repeat (10) tick();

    // Reset mid-note silences CTL without waiting for a clock edge.
    c0 = cyc;
    expect_at(c0 + 2, 0, K_CTL, 'h99); expect_at(c0 + 4, 0, K_CTL, 'h99);
    expect_at(c0 + 5, 0, K_CTL, 0);
    for (int i = 6; i <= 12; i++) begin
      expect_at(c0 + i, 0, K_CTL, 0);
      expect_at(c0 + i, 0, K_DONE, 0);
    end
    expect_at(c0 + 8, 0, K_BUSY, 0); expect_at(c0 + 8, 0, K_LVL, 0);
    wr(0, 5, 'h99);
    repeat (4) tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    repeat (10) tick();

    for (int i = 0; i < 100 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
